// File: rtl/cps1_colour_mixer.sv
// cps1_colour_mixer: CPS-1 final video stage, picks the visible layer pixel,
// looks it up in a 2048-entry palette and outputs RGB with delayed blanking.
// The palette is loaded from VRAM by a copy engine started on a pal_copy rising edge.
// Optional: define COLMIX_LAYER_MASK_EN to let gfx_en mask layers (ignored otherwise).
// Ports:
//   clk, rstn                   clock, async active-low reset
//   pxl_cen                     pixel clock enable, advances the video pipeline
//   HB, VB                      blanking in, active high
//   LHBL_dly, LVBL_dly          ~HB / ~VB delayed by PXL_LAT pxl_cen ticks
//   gfx_en                      layer enables {obj, scr3, scr2, scr1}
//   pal_copy, pal_base          copy request (rising edge) and VRAM source base
//   vram_addr, vram_cs          VRAM word address [17:1] and request
//   vram_data, vram_ok          VRAM read data and valid
//   scr1/2/3_pxl, obj_pxl       layer pixels {palette[4:0], colour[3:0]}
//   red, green, blue            8-bit RGB output
module cps1_colour_mixer #(
  parameter int PAL_WORDS = 2048,
  parameter int PXL_LAT   = 3
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        pxl_cen,
  input  logic        HB,
  input  logic        VB,
  output logic        LHBL_dly,
  output logic        LVBL_dly,
  input  logic [3:0]  gfx_en,
  input  logic        pal_copy,
  input  logic [15:0] pal_base,
  output logic [16:0] vram_addr,
  input  logic [15:0] vram_data,
  input  logic        vram_ok,
  output logic        vram_cs,
  input  logic [8:0]  scr1_pxl,
  input  logic [8:0]  scr2_pxl,
  input  logic [8:0]  scr3_pxl,
  input  logic [8:0]  obj_pxl,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DATA} st_t;
  logic [3:0]  en;
  logic [3:0]  opaque;
  logic [10:0] mix_idx;
  logic        mix_blk;
  logic [10:0] s1_idx;
  logic        s1_blk;
  logic        s2_blk;
  logic [15:0] s2_pal;
  logic [PXL_LAT-1:0] hsh;
  logic [PXL_LAT-1:0] vsh;
  logic [15:0] pal [PAL_WORDS];
  st_t         st;
  logic [10:0] idx;
  logic [9:0]  base;
  logic        copy_l;
  logic        rise;
  logic        wr_en;
  logic        unused_ok;
`ifdef COLMIX_LAYER_MASK_EN
  assign en = gfx_en;
  assign unused_ok = &{1'b0, pal_base[15:10]};
`else
  assign en = 4'hF;
  assign unused_ok = &{1'b0, pal_base[15:10], gfx_en};
`endif
  // bit order follows gfx_en: {obj, scr3, scr2, scr1}
  assign opaque = en & {obj_pxl[3:0] != 4'hF, scr3_pxl[3:0] != 4'hF,
                        scr2_pxl[3:0] != 4'hF, scr1_pxl[3:0] != 4'hF};
  always_comb begin
    mix_idx = opaque[3] ? {2'd0, obj_pxl} :
              opaque[0] ? {2'd1, scr1_pxl} :
              opaque[1] ? {2'd2, scr2_pxl} : {2'd3, scr3_pxl};
    // nothing opaque falls back to scr3's entry unless scr3 itself is disabled
    mix_blk = ~|opaque & ~en[2];
  end
  function automatic logic [7:0] conv(input logic [3:0] c, input logic [3:0] b);
    logic [12:0] p;
    p = 13'({c, c}) * 13'({1'b0, b} + 5'd16);
    return 8'(p >> 5);
  endfunction
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      s1_idx <= '0;
      s1_blk <= 1'b1;
      s2_blk <= 1'b1;
      hsh    <= '0;
      vsh    <= '0;
      red    <= '0;
      green  <= '0;
      blue   <= '0;
    end else if (pxl_cen) begin
      s1_idx <= mix_idx;
      s1_blk <= mix_blk;
      s2_blk <= s1_blk;
      hsh    <= {hsh[PXL_LAT-2:0], ~HB};
      vsh    <= {vsh[PXL_LAT-2:0], ~VB};
      // gate with the blanking bits that land in the output stage on this same tick
      {red, green, blue} <= (s2_blk | ~hsh[PXL_LAT-2] | ~vsh[PXL_LAT-2]) ? 24'd0 :
        {conv(s2_pal[11:8], s2_pal[15:12]), conv(s2_pal[7:4], s2_pal[15:12]),
         conv(s2_pal[3:0], s2_pal[15:12])};
    end
  assign LHBL_dly = hsh[PXL_LAT-1];
  assign LVBL_dly = vsh[PXL_LAT-1];
  always_ff @(posedge clk)
    if (pxl_cen) s2_pal <= pal[s1_idx];
  always_ff @(posedge clk)
    if (wr_en) pal[idx] <= vram_data;
  assign rise  = pal_copy & ~copy_l;
  assign wr_en = st == DATA && vram_ok && !rise;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      st        <= IDLE;
      idx       <= '0;
      base      <= '0;
      copy_l    <= 1'b0;
      vram_cs   <= 1'b0;
      vram_addr <= '0;
    end else begin
      copy_l <= pal_copy;
      if (rise) begin
        base <= pal_base[9:0];
        idx  <= '0;
        st   <= REQ;
      end else if (st == REQ) begin
        vram_addr <= {base, 7'd0} + 17'(idx);
        vram_cs   <= 1'b1;
        st        <= WAIT;
      end else if (st == WAIT) begin
        st <= DATA;
      end else if (st == DATA && vram_ok) begin
        idx <= idx + 11'd1;
        st  <= idx == 11'(PAL_WORDS - 1) ? IDLE : REQ;
        if (idx == 11'(PAL_WORDS - 1)) vram_cs <= 1'b0;
      end
    end
endmodule

// File: tb/tb_cps1_colour_mixer.sv
// tb_cps1_colour_mixer: directed bench for cps1_colour_mixer with a lagging VRAM model.
module tb_cps1_colour_mixer;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        pxl_cen = 1'b0;
  logic        HB = 1'b1;
  logic        VB = 1'b1;
  logic        LHBL_dly, LVBL_dly;
  logic [3:0]  gfx_en = 4'hF;
  logic        pal_copy = 1'b0;
  logic [15:0] pal_base = '0;
  logic [16:0] vram_addr;
  logic [15:0] vram_data;
  logic        vram_ok;
  logic        vram_cs;
  logic [8:0]  scr1_pxl = 9'h1FF, scr2_pxl = 9'h1FF, scr3_pxl = 9'h1FF, obj_pxl = 9'h1FF;
  logic [7:0]  red, green, blue;
  logic [15:0] tbv [2048];
  logic [16:0] last_addr = '0;
  int          lag = 0;
  int          total = 0;
  int          bad = 0;
  int          n;
  int          t;
  logic [16:0] fa, la;

  cps1_colour_mixer dut (
    .clk(clk), .rstn(rstn), .pxl_cen(pxl_cen), .HB(HB), .VB(VB),
    .LHBL_dly(LHBL_dly), .LVBL_dly(LVBL_dly), .gfx_en(gfx_en),
    .pal_copy(pal_copy), .pal_base(pal_base), .vram_addr(vram_addr),
    .vram_data(vram_data), .vram_ok(vram_ok), .vram_cs(vram_cs),
    .scr1_pxl(scr1_pxl), .scr2_pxl(scr2_pxl), .scr3_pxl(scr3_pxl), .obj_pxl(obj_pxl),
    .red(red), .green(green), .blue(blue)
  );

  initial forever #5 clk = ~clk;

  // VRAM answers two cycles after the address settles
  always @(posedge clk)
    if (vram_addr != last_addr) begin
      last_addr <= vram_addr;
      lag <= 0;
    end else if (lag < 3) lag <= lag + 1;
  assign vram_ok   = vram_cs && vram_addr == last_addr && lag >= 2;
  assign vram_data = tbv[vram_addr[10:0]];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk) pxl_cen = 1'b1;
    @(negedge clk) pxl_cen = 1'b0;
  endtask

  task automatic pix(input logic [8:0] o, input logic [8:0] s1, input logic [8:0] s2,
                     input logic [8:0] s3, input logic [3:0] e);
    obj_pxl = o;
    scr1_pxl = s1;
    scr2_pxl = s2;
    scr3_pxl = s3;
    gfx_en = e;
    repeat (3) tick();
  endtask

  task automatic run_copy(input logic [15:0] b);
    logic [16:0] pv;
    @(negedge clk);
    pal_base = b;
    pal_copy = 1'b1;
    @(negedge clk);
    pal_copy = 1'b0;
    n = 0; fa = '1; la = '0; pv = '1; t = 0;
    while (t < 30000 && (n == 0 || vram_cs)) begin
      if (vram_cs && vram_addr != pv) begin
        if (n == 0) fa = vram_addr;
        n++;
        pv = vram_addr;
        la = vram_addr;
      end
      @(negedge clk);
      t++;
    end
    chk("copy_in_time", t < 30000, 1);
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) tbv[i] = 16'(i);
    tbv[11'h012] = 16'hFF80;
    tbv[11'h234] = 16'h0F00;
    tbv[11'h456] = 16'h8123;
    tbv[11'h678] = 16'h0A5C;
    repeat (3) @(negedge clk);
    chk("rst_rgb", {red, green, blue}, 24'h0);
    chk("rst_lhbl", LHBL_dly, 0);
    chk("rst_lvbl", LVBL_dly, 0);
    chk("rst_cs", vram_cs, 0);
    chk("rst_addr", vram_addr, 17'h0);
    rstn = 1'b1;
    HB = 1'b0;
    VB = 1'b0;
    run_copy(16'h0010);
    chk("copy_reqs", n, 2048);
    chk("copy_first", fa, 17'h00800);
    chk("copy_last", la, 17'h00FFF);
    chk("copy_cs_off", vram_cs, 0);
    pix(9'h012, 9'h034, 9'h056, 9'h078, 4'hF);
    chk("obj_wins", {red, green, blue}, 24'hF78300);
    chk("lhbl_up", LHBL_dly, 1);
    pix(9'h01F, 9'h034, 9'h056, 9'h078, 4'hF);
    chk("scr1_wins", {red, green, blue}, 24'h7F0000);
    pix(9'h01F, 9'h03F, 9'h056, 9'h078, 4'hF);
    chk("scr2_wins", {red, green, blue}, 24'h0C1926);
    pix(9'h01F, 9'h03F, 9'h05F, 9'h078, 4'hF);
    chk("scr3_wins", {red, green, blue}, 24'h552A66);
    pix(9'h01F, 9'h03F, 9'h05F, 9'h07F, 4'hF);
    chk("all_clear", {red, green, blue}, 24'h333B7F);
    pix(9'h01F, 9'h03F, 9'h1A3, 9'h07F, 4'hF);
    chk("plain_entry", {red, green, blue}, 24'h2A5519);
`ifdef COLMIX_LAYER_MASK_EN
    pix(9'h01F, 9'h034, 9'h056, 9'h078, 4'b1110);
    chk("mask_scr1", {red, green, blue}, 24'h0C1926);
    pix(9'h01F, 9'h034, 9'h056, 9'h078, 4'b0000);
    chk("mask_all", {red, green, blue}, 24'h0);
`else
    pix(9'h01F, 9'h034, 9'h056, 9'h078, 4'b0000);
    chk("mask_ignored", {red, green, blue}, 24'h7F0000);
`endif
    pix(9'h012, 9'h034, 9'h056, 9'h078, 4'hF);
    HB = 1'b1;
    tick();
    chk("hb_t1", LHBL_dly, 1);
    tick();
    chk("hb_t2", LHBL_dly, 1);
    chk("hb_t2_rgb", {red, green, blue}, 24'hF78300);
    tick();
    chk("hb_t3", LHBL_dly, 0);
    chk("hb_rgb", {red, green, blue}, 24'h0);
    HB = 1'b0;
    repeat (3) tick();
    chk("hb_back", {red, green, blue}, 24'hF78300);
    VB = 1'b1;
    repeat (3) tick();
    chk("vb_low", LVBL_dly, 0);
    chk("vb_rgb", {red, green, blue}, 24'h0);
    VB = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    pal_base = 16'h0020;
    pal_copy = 1'b1;
    @(negedge clk);
    pal_copy = 1'b0;
    t = 0;
    while (vram_addr != 17'h01064 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("rs_reach100", vram_addr, 17'h01064);
    pal_base = 16'h0010;
    pal_copy = 1'b1;
    @(negedge clk);
    pal_copy = 1'b0;
    t = 0;
    while (vram_addr == 17'h01064 && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("rs_first", vram_addr, 17'h00800);
    t = 0;
    while (vram_addr == 17'h00800 && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("rs_second", vram_addr, 17'h00801);
    t = 0;
    while (vram_cs && t < 20000) begin
      @(negedge clk);
      t++;
    end
    chk("rs_done", vram_cs, 0);
    chk("rs_last", vram_addr, 17'h00FFF);
    pix(9'h01F, 9'h034, 9'h056, 9'h078, 4'hF);
    chk("rs_palette", {red, green, blue}, 24'h7F0000);
    @(negedge clk);
    pal_base = 16'h0010;
    pal_copy = 1'b1;
    @(negedge clk);
    pal_copy = 1'b0;
    repeat (50) @(negedge clk);
    chk("pre_rst_cs", vram_cs, 1);
    chk("pre_rst_red", red, 8'h7F);
    #2 rstn = 1'b0;
    #1;
    chk("arst_cs", vram_cs, 0);
    chk("arst_addr", vram_addr, 17'h0);
    chk("arst_rgb", {red, green, blue}, 24'h0);
    chk("arst_blank", {LHBL_dly, LVBL_dly}, 2'b00);
    @(negedge clk);
    rstn = 1'b1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
